enemy_laser: RTL and testbench
==============================

// Module: enemy_laser
// PURPOSE
//  Enemy-side projectile engine; produces the hit_i pulse that the player ship FSM consumes.
//  Accepts a fire request from the enemy fleet and drops one laser per frame tick.
//  Tests the laser against the player's left/right span and the player's row; pulses hit_o on contact.
//  Sits between the enemy fleet, the player block and the VGA pixel mux.
// PARAMETERS
//  color_p       12'hF00  laser colour {R,G,B}, 4 bits each
//  speed_p       10'd4    pixels moved down per frame tick
//  laser_h_p     10'd8    laser height in pixels; width fixed at 2
//  player_top_p  10'd440  top row of the player ship
//  player_bot_p  10'd460  bottom row of the player ship
//  screen_bot_p  10'd480  y at or beyond which the laser despawns
//  cooldown_p    8'd30    frame ticks between despawn/resume and the next accepted fire
// PORTS
//  clk_i           in   1   clock
//  reset_n_i       in   1   asynchronous active-low reset
//  frame_tick_i    in   1   one-cycle pulse per video frame
//  fire_i          in   1   fleet requests a shot
//  fire_x_i        in   10  spawn x (gun column of the firing enemy)
//  fire_y_i        in   10  spawn y (top of the laser)
//  player_left_i   in   10  player left edge
//  player_right_i  in   10  player right edge
//  player_alive_i  in   1   player has lives; low forces the laser clear
//  freeze_i        in   1   pause; holds all state, counters and position
//  resume_i        in   1   center button; leaves WAIT_RESUME
//  fire_ack_o      out  1   combinational; high in the cycle fire_i is accepted
//  hit_o           out  1   one-cycle registered pulse to the player's hit_i
//  laser_active_o  out  1   laser on screen (FALLING)
//  laser_x_o       out  10  laser left column
//  laser_y_o       out  10  laser top row
//  laser_red_o/laser_green_o/laser_blue_o  out  4 each  colour from color_p
//  pres_state_o    out  5   one-hot present state for debug
// BEHAVIOUR
//  Reset (async, reset_n_i=0): state=IDLE; x=y=0; cooldown=0; hit_o=0; laser_active_o=0.
//  One-hot states: IDLE 00001, FALLING 00010, HIT 00100, WAIT_RESUME 01000, COOLDOWN 10000.
//    Any other encoding forces IDLE on the next edge.
//  IDLE: fire_i & player_alive_i & ~freeze_i
//    -> fire_ack_o=1; latch x=fire_x_i, y=fire_y_i; FALLING next cycle.
//    fire_i in any other state or condition is ignored with fire_ack_o=0; no queueing.
//  FALLING: on frame_tick_i, y <= min(y+speed_p, 1023); 11-bit sum, never wraps.
//    Contact is checked every cycle on the registered x/y:
//    (y+laser_h_p >= player_top_p) & (y <= player_bot_p) & (x+1 >= player_left_i) & (x <= player_right_i).
//    Span edges are inclusive.
//    Contact -> HIT.
//    Else y >= screen_bot_p -> COOLDOWN, loading cooldown=cooldown_p.
//    Contact wins over despawn when both hold in the same cycle.
//  HIT: hit_o=1 for exactly this cycle; laser cleared; -> WAIT_RESUME.
//  WAIT_RESUME: holds until resume_i, then -> COOLDOWN, loading cooldown=cooldown_p.
//  COOLDOWN: cooldown decrements on frame_tick_i; at 0 -> IDLE.
//    Counter loaded with 0 exits on the next cycle.
//  freeze_i=1: all registers hold, ticks are ignored, hit_o is not generated.
//    HIT already entered still completes its single-cycle pulse.
//  player_alive_i=0 in any state: -> IDLE next cycle; laser cleared; hit_o=0.
//    This does not cancel a HIT cycle that is already in progress.
//  laser_active_o = (state==FALLING). x and y read 0 whenever inactive.
// CONFIGURATION
//  ENEMY_LASER_JITTER_EN defined:
//    8-bit Galois LFSR (taps 8,6,5,4; seed 8'h5A on reset) advances on every frame_tick_i.
//    Cooldown loads cooldown_p + lfsr[3:0] (0..15 extra ticks).
//  Undefined: cooldown loads exactly cooldown_p; no LFSR logic is synthesised.
// STRUCTURE
//  Shared package space_invaders_pkg:
//    enemy_laser_state_t enum; screen constants (screen_bot, left/right borders 9/630).
//  Sub-module enemy_laser_lfsr (8-bit, enable=frame_tick_i); instantiated only under ENEMY_LASER_JITTER_EN.
//  Cooldown counter and position registers stay inline, on the async-reset flop style.
// TESTING
//  1 Player 249..289; fire x=269 y=100 -> fire_ack_o=1; hit_o pulses one cycle after tick 83 (y=432); then WAIT_RESUME.
//  2 Fire x=100 y=100, no contact -> despawn after tick 95 (y=480); COOLDOWN; IDLE after 30 ticks; with JITTER 30..45 ticks.
//  3 x=289 (equals player_right_i), y reaches 432 -> hit; x=290 -> miss.
//  4 freeze_i for 20 ticks mid-flight at y=200 -> y stays 200, no hit; resumes at 204 on the next tick after release.
//  5 fire_i held during FALLING -> fire_ack_o=0 and x/y unchanged; reset_n_i low mid-flight -> immediate IDLE, all outputs 0.
//  6 player_alive_i=0 at y=300 -> IDLE next cycle, laser_active_o=0; WAIT_RESUME + resume_i -> COOLDOWN (30 ticks).

Source files
------------

// File: rtl/space_invaders_pkg.sv
// Shared types and screen constants for the space invaders blocks.
// Consumed by enemy_laser and its optional LFSR (ENEMY_LASER_JITTER_EN).
package space_invaders_pkg;

    typedef enum logic [4:0] {
        EL_IDLE        = 5'b00001,
        EL_FALLING     = 5'b00010,
        EL_HIT         = 5'b00100,
        EL_WAIT_RESUME = 5'b01000,
        EL_COOLDOWN    = 5'b10000
    } enemy_laser_state_t;

    localparam logic [9:0] SCREEN_BOT   = 10'd480;
    localparam logic [9:0] LEFT_BORDER  = 10'd9;
    localparam logic [9:0] RIGHT_BORDER = 10'd630;

endpackage

// File: rtl/enemy_laser_lfsr.sv
// 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) for cooldown jitter.
// Only compiled when ENEMY_LASER_JITTER_EN is defined.
`ifdef ENEMY_LASER_JITTER_EN
module enemy_laser_lfsr (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       en_i,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lfsr_q <= 8'h5A;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule
`endif

// File: rtl/enemy_laser.sv
// Enemy projectile engine: spawn, fall, player contact, cooldown.
// Optional cooldown jitter under ENEMY_LASER_JITTER_EN.
module enemy_laser
    import space_invaders_pkg::*;
#(
    parameter logic [11:0] color_p      = 12'hF00,
    parameter logic [9:0]  speed_p      = 10'd4,
    parameter logic [9:0]  laser_h_p    = 10'd8,
    parameter logic [9:0]  player_top_p = 10'd440,
    parameter logic [9:0]  player_bot_p = 10'd460,
    parameter logic [9:0]  screen_bot_p = SCREEN_BOT,
    parameter logic [7:0]  cooldown_p   = 8'd30
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       frame_tick_i,
    input  logic       fire_i,
    input  logic [9:0] fire_x_i,
    input  logic [9:0] fire_y_i,
    input  logic [9:0] player_left_i,
    input  logic [9:0] player_right_i,
    input  logic       player_alive_i,
    input  logic       freeze_i,
    input  logic       resume_i,
    output logic       fire_ack_o,
    output logic       hit_o,
    output logic       laser_active_o,
    output logic [9:0] laser_x_o,
    output logic [9:0] laser_y_o,
    output logic [3:0] laser_red_o,
    output logic [3:0] laser_green_o,
    output logic [3:0] laser_blue_o,
    output logic [4:0] pres_state_o
);

    enemy_laser_state_t state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [7:0]  cool_q, cool_d;
    logic        hit_q, hit_d;
    logic [7:0]  cool_load;
    logic [10:0] y_bot;
    logic [10:0] x_right;
    logic [10:0] y_sum;
    logic [9:0]  y_next;
    logic        contact;

`ifdef ENEMY_LASER_JITTER_EN
    logic [7:0] lfsr;

    enemy_laser_lfsr u_lfsr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (frame_tick_i),
        .lfsr_o    (lfsr)
    );

    assign cool_load = cooldown_p + {4'b0000, lfsr[3:0]};
`else
    assign cool_load = cooldown_p;
`endif

    // 11-bit arithmetic so edge tests and the fall step never wrap
    assign y_bot   = {1'b0, y_q} + {1'b0, laser_h_p};
    assign x_right = {1'b0, x_q} + 11'd1;
    assign y_sum   = {1'b0, y_q} + {1'b0, speed_p};
    assign y_next  = y_sum[10] ? 10'h3FF : y_sum[9:0];

    assign contact = (y_bot >= {1'b0, player_top_p})
                   && (y_q <= player_bot_p)
                   && (x_right >= {1'b0, player_left_i})
                   && (x_q <= player_right_i);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        cool_d     = cool_q;
        fire_ack_o = 1'b0;
        case (state_q)
            EL_IDLE: begin
                if (fire_i && player_alive_i && !freeze_i) begin
                    fire_ack_o = 1'b1;
                    x_d        = fire_x_i;
                    y_d        = fire_y_i;
                    state_d    = EL_FALLING;
                end
            end
            EL_FALLING: begin
                if (!freeze_i) begin
                    if (contact) begin
                        state_d = EL_HIT;
                        x_d     = '0;
                        y_d     = '0;
                    end else if (y_q >= screen_bot_p) begin
                        state_d = EL_COOLDOWN;
                        cool_d  = cool_load;
                        x_d     = '0;
                        y_d     = '0;
                    end else if (frame_tick_i) begin
                        y_d = y_next;
                    end
                end
            end
            EL_HIT: begin
                // the pulse finishes even under freeze
                state_d = EL_WAIT_RESUME;
            end
            EL_WAIT_RESUME: begin
                if (!freeze_i && resume_i) begin
                    state_d = EL_COOLDOWN;
                    cool_d  = cool_load;
                end
            end
            EL_COOLDOWN: begin
                if (!freeze_i) begin
                    if (cool_q == 8'd0) begin
                        state_d = EL_IDLE;
                    end else if (frame_tick_i) begin
                        cool_d = cool_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = EL_IDLE;
                x_d     = '0;
                y_d     = '0;
                cool_d  = '0;
            end
        endcase
        if (!player_alive_i) begin
            state_d = EL_IDLE;
            x_d     = '0;
            y_d     = '0;
            cool_d  = '0;
        end
        hit_d = (state_d == EL_HIT);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= EL_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cool_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cool_q  <= cool_d;
            hit_q   <= hit_d;
        end
    end

    assign hit_o          = hit_q;
    assign laser_active_o = (state_q == EL_FALLING);
    assign laser_x_o      = laser_active_o ? x_q : 10'd0;
    assign laser_y_o      = laser_active_o ? y_q : 10'd0;
    assign laser_red_o    = color_p[11:8];
    assign laser_green_o  = color_p[7:4];
    assign laser_blue_o   = color_p[3:0];
    assign pres_state_o   = state_q;

endmodule

// File: tb/tb_enemy_laser.sv
// Directed testbench for enemy_laser.
// Cooldown length checks widen when ENEMY_LASER_JITTER_EN is defined.
module tb_enemy_laser;

    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_FALL = 5'b00010;
    localparam logic [4:0] S_HIT  = 5'b00100;
    localparam logic [4:0] S_WAIT = 5'b01000;
    localparam logic [4:0] S_COOL = 5'b10000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_tick;
    logic       fire;
    logic [9:0] fire_x;
    logic [9:0] fire_y;
    logic [9:0] p_left;
    logic [9:0] p_right;
    logic       alive;
    logic       freeze;
    logic       resume;
    logic       fire_ack;
    logic       hit;
    logic       active;
    logic [9:0] lx;
    logic [9:0] ly;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic [4:0] pstate;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    enemy_laser dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .frame_tick_i   (frame_tick),
        .fire_i         (fire),
        .fire_x_i       (fire_x),
        .fire_y_i       (fire_y),
        .player_left_i  (p_left),
        .player_right_i (p_right),
        .player_alive_i (alive),
        .freeze_i       (freeze),
        .resume_i       (resume),
        .fire_ack_o     (fire_ack),
        .hit_o          (hit),
        .laser_active_o (active),
        .laser_x_o      (lx),
        .laser_y_o      (ly),
        .laser_red_o    (red),
        .laser_green_o  (green),
        .laser_blue_o   (blue),
        .pres_state_o   (pstate)
    );

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n, output logic saw_hit);
        saw_hit = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (hit) saw_hit = 1'b1;
        end
    endtask

    task automatic do_fire(input logic [9:0] x, input logic [9:0] y,
                           output logic ack);
        @(negedge clk);
        fire   = 1'b1;
        fire_x = x;
        fire_y = y;
        #1 ack = fire_ack;
        @(negedge clk);
        fire = 1'b0;
    endtask

    task automatic to_idle();
        @(negedge clk);
        alive = 1'b0;
        @(negedge clk);
        alive = 1'b1;
    endtask

    task automatic count_cooldown(output int n);
        n = 0;
        for (int i = 1; i <= 60 && n == 0; i++) begin
            tick();
            @(negedge clk);
            if (pstate == S_IDLE) n = i;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (pstate !== S_IDLE) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", pstate, S_IDLE);
        end
        checks++;
        if ({hit, active, fire_ack, lx, ly} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%b %0d %0d exp=000 0 0",
                     hit, active, fire_ack, lx, ly);
        end
        checks++;
        if ({red, green, blue} !== 12'hF00) begin
            failures++;
            $display("FAIL colour got=%h exp=f00", {red, green, blue});
        end
    endtask

    task automatic test_hit();
        logic ack;
        logic early;
        p_left  = 10'd249;
        p_right = 10'd289;
        do_fire(10'd269, 10'd100, ack);
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL hit_fire_ack got=%b exp=1", ack);
        end
        checks++;
        if (active !== 1'b1 || lx !== 10'd269 || ly !== 10'd100) begin
            failures++;
            $display("FAIL hit_spawn got=%b %0d %0d exp=1 269 100",
                     active, lx, ly);
        end
        ticks(83, early);
        checks++;
        if (early !== 1'b0 || ly !== 10'd432) begin
            failures++;
            $display("FAIL hit_pre got=%b y=%0d exp=0 y=432", early, ly);
        end
        @(negedge clk);
        checks++;
        if (hit !== 1'b1 || pstate !== S_HIT || active !== 1'b0) begin
            failures++;
            $display("FAIL hit_pulse got=%b %b %b exp=1 %b 0",
                     hit, pstate, active, S_HIT);
        end
        @(negedge clk);
        checks++;
        if (hit !== 1'b0 || pstate !== S_WAIT) begin
            failures++;
            $display("FAIL hit_after got=%b %b exp=0 %b", hit, pstate, S_WAIT);
        end
        to_idle();
    endtask

    task automatic test_despawn();
        logic ack;
        logic h;
        int   n;
        do_fire(10'd100, 10'd100, ack);
        ticks(94, h);
        checks++;
        if (pstate !== S_FALL || ly !== 10'd476) begin
            failures++;
            $display("FAIL despawn_pre got=%b y=%0d exp=%b y=476",
                     pstate, ly, S_FALL);
        end
        tick();
        checks++;
        if (ly !== 10'd480 || active !== 1'b1) begin
            failures++;
            $display("FAIL despawn_y got=%0d act=%b exp=480 act=1", ly, active);
        end
        @(negedge clk);
        checks++;
        if (pstate !== S_COOL || active !== 1'b0 || h !== 1'b0) begin
            failures++;
            $display("FAIL despawn_cool got=%b act=%b hit=%b exp=%b 0 0",
                     pstate, active, h, S_COOL);
        end
        count_cooldown(n);
        checks++;
`ifdef ENEMY_LASER_JITTER_EN
        if (n < 30 || n > 45) begin
`else
        if (n != 30) begin
`endif
            failures++;
            $display("FAIL despawn_cooldown got=%0d ticks exp=30", n);
        end
    endtask

    task automatic test_edges();
        logic [9:0] xs [4];
        logic       exp_hit [4];
        logic       ack;
        logic       h;
        xs[0] = 10'd289; exp_hit[0] = 1'b1;
        xs[1] = 10'd290; exp_hit[1] = 1'b0;
        xs[2] = 10'd248; exp_hit[2] = 1'b1;
        xs[3] = 10'd247; exp_hit[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_fire(xs[i], 10'd100, ack);
            ticks(83, h);
            @(negedge clk);
            checks++;
            if (hit !== exp_hit[i] || h !== 1'b0) begin
                failures++;
                $display("FAIL edge_x%0d got=%b exp=%b", xs[i], hit, exp_hit[i]);
            end
            to_idle();
        end
    endtask

    task automatic test_freeze();
        logic ack;
        logic h;
        logic hf;
        do_fire(10'd100, 10'd100, ack);
        ticks(25, h);
        @(negedge clk);
        freeze = 1'b1;
        ticks(20, hf);
        checks++;
        if (ly !== 10'd200 || pstate !== S_FALL || hf !== 1'b0) begin
            failures++;
            $display("FAIL freeze_hold got=%0d %b %b exp=200 %b 0",
                     ly, pstate, hf, S_FALL);
        end
        @(negedge clk);
        freeze = 1'b0;
        tick();
        checks++;
        if (ly !== 10'd204) begin
            failures++;
            $display("FAIL freeze_release got=%0d exp=204", ly);
        end
        to_idle();
    endtask

    task automatic test_fire_ignored_and_reset();
        logic ack;
        logic h;
        logic bad_ack;
        do_fire(10'd100, 10'd100, ack);
        ticks(2, h);
        bad_ack = 1'b0;
        @(negedge clk);
        fire   = 1'b1;
        fire_x = 10'd500;
        fire_y = 10'd7;
        for (int i = 0; i < 4; i++) begin
            #1 if (fire_ack) bad_ack = 1'b1;
            @(negedge clk);
        end
        fire = 1'b0;
        checks++;
        if (bad_ack !== 1'b0 || lx !== 10'd100 || ly !== 10'd108) begin
            failures++;
            $display("FAIL fire_ignored got=%b %0d %0d exp=0 100 108",
                     bad_ack, lx, ly);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (pstate !== S_IDLE || {hit, active, lx, ly} !== 22'd0) begin
            failures++;
            $display("FAIL midflight_reset got=%b %b %b %0d %0d exp=%b 0 0 0 0",
                     pstate, hit, active, lx, ly, S_IDLE);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_alive_and_resume();
        logic ack;
        logic h;
        int   n;
        do_fire(10'd100, 10'd100, ack);
        ticks(50, h);
        @(negedge clk);
        alive = 1'b0;
        @(negedge clk);
        alive = 1'b1;
        checks++;
        if (pstate !== S_IDLE || active !== 1'b0 || ly !== 10'd0) begin
            failures++;
            $display("FAIL alive_clear got=%b %b %0d exp=%b 0 0",
                     pstate, active, ly, S_IDLE);
        end
        do_fire(10'd269, 10'd100, ack);
        ticks(83, h);
        repeat (2) @(negedge clk);
        checks++;
        if (pstate !== S_WAIT) begin
            failures++;
            $display("FAIL resume_wait got=%b exp=%b", pstate, S_WAIT);
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        checks++;
        if (pstate !== S_COOL) begin
            failures++;
            $display("FAIL resume_cool got=%b exp=%b", pstate, S_COOL);
        end
        count_cooldown(n);
        checks++;
`ifdef ENEMY_LASER_JITTER_EN
        if (n < 30 || n > 45) begin
`else
        if (n != 30) begin
`endif
            failures++;
            $display("FAIL resume_cooldown got=%0d ticks exp=30", n);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        fire       = 1'b0;
        fire_x     = '0;
        fire_y     = '0;
        p_left     = 10'd249;
        p_right    = 10'd289;
        alive      = 1'b1;
        freeze     = 1'b0;
        resume     = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        test_hit();
        test_despawn();
        test_edges();
        test_freeze();
        test_fire_ignored_and_reset();
        test_alive_and_resume();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
